// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// Every operation takes a fixed 34 edges; signed ops work on magnitudes and fix signs at the end.
module mul_div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        hi_wr,
    input  logic        lo_wr,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic        is_div;
    logic        neg_q;
    logic        neg_r;
    logic [31:0] opb;
    logic [31:0] rs_lat;
    // MUL: {upper partial product, remaining multiplier bits}; DIV: {remainder, dividend/quotient}
    logic [63:0] work;

    logic [32:0] mul_sum;
    logic [32:0] div_sh;
    logic        div_ge;
    logic [31:0] div_sub;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    function automatic logic [31:0] abs32(input logic signed [31:0] v, input logic is_signed);
        return (is_signed && v < 0) ? -v : v;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v, input logic neg);
        return neg ? (~v + 64'd1) : v;
    endfunction

    function automatic logic [31:0] neg32(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    assign busy    = (state != IDLE);
    assign mul_sum = {1'b0, work[63:32]} + (work[0] ? {1'b0, opb} : 33'd0);
    assign div_sh  = {work[63:32], work[31]};
    assign div_ge  = (div_sh >= {1'b0, opb});
    // The remainder stays below the divisor, so the difference always fits in 32 bits.
    assign div_sub = div_sh[31:0] - opb;

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        if (!is_div) begin
            {res_hi, res_lo} = neg64(work, neg_q);
        end else if (opb == 32'd0) begin
            res_hi = rs_lat;
            res_lo = 32'hFFFF_FFFF;
        end else begin
            res_hi = neg32(work[63:32], neg_r);
            res_lo = neg32(work[31:0], neg_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 5'd0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            opb      <= 32'd0;
            rs_lat   <= 32'd0;
            work     <= 64'd0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        opb      <= abs32(rt_data, op[0]);
                        work     <= {32'd0, abs32(rs_data, op[0])};
                        rs_lat   <= rs_data;
                        is_div   <= op[1];
                        neg_q    <= op[0] & (rs_data[31] ^ rt_data[31]);
                        neg_r    <= op[0] & rs_data[31];
                        div_zero <= 1'b0;
                        cnt      <= 5'd0;
                        state    <= op[1] ? DIV : MUL;
                    end else begin
                        if (hi_wr) hi <= rs_data;
                        if (lo_wr) lo <= rs_data;
                    end
                end
                MUL: begin
                    work <= {mul_sum, work[31:1]};
                    cnt  <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= FIX;
                end
                DIV: begin
                    work <= div_ge ? {div_sub, work[30:0], 1'b1}
                                   : {div_sh[31:0], work[30:0], 1'b0};
                    cnt  <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= FIX;
                end
                FIX: begin
                    hi       <= res_hi;
                    lo       <= res_lo;
                    div_zero <= is_div && (opb == 32'd0);
                    done     <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  in  1  reset, asynchronous, active-low.
REQ-003 start  in  1  request; sampled on a rising edge only while busy=0.
REQ-004 op  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start.
REQ-005 rs_data  in  32  multiplicand / dividend; also MTHI/MTLO write data.
REQ-006 rt_data  in  32  multiplier / divisor.
REQ-007 hi_wr  in  1  MTHI: HI <= rs_data.
REQ-008 lo_wr  in  1  MTLO: LO <= rs_data.
REQ-009 busy  out  1  high while an operation is in progress.
REQ-010 done  out  1  one-cycle pulse; HI/LO valid from that cycle on.
REQ-011 div_zero  out  1  last completed division had rt_data=0; held until the next accepted start.
REQ-012 hi  out  32  HI register (high product / remainder).
REQ-013 lo  out  32  LO register (low product / quotient).

Function
REQ-014 States: IDLE, MUL, DIV, FIX; busy=1 in every state except IDLE.
REQ-015 IDLE, start=1 at edge E0: latch op, operands, absolute values (signed ops), result signs; counter=0; go to MUL (op[1]=0) or DIV (op[1]=1).
REQ-016 MUL: one shift-add iteration per edge, E1..E32; counter increments; at counter=31 go to FIX.
REQ-017 DIV: one restoring shift-subtract iteration per edge, E1..E32; same counter rule; at counter=31 go to FIX.
REQ-018 FIX, edge E33: apply sign correction, write HI/LO, set done=1, go to IDLE (busy=0 after E33).
REQ-019 Latency fixed at 34 edges E0..E33 for every op; done high exactly the cycle after E33, cleared at E34.
REQ-020 MULT/MULTU: {HI,LO} = full 64-bit product; MULT product negated iff operand signs differ.
REQ-021 DIV/DIVU: LO = quotient truncated toward zero, HI = remainder; signed quotient negative iff signs differ, remainder takes dividend sign.
REQ-022 Divide by zero: no trap; LO=0xFFFFFFFF, HI=rs_data as latched, div_zero=1; same 34-edge latency.
REQ-023 DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000, div_zero=0.
REQ-024 start while busy=1 ignored; no queuing; HI/LO/state unaffected.
REQ-025 hi_wr/lo_wr honoured only in IDLE with start=0; ignored while busy or when start=1 in the same cycle (start wins).
REQ-026 hi_wr and lo_wr together: both HI and LO take rs_data.
REQ-027 HI/LO change only at FIX or by an honoured hi_wr/lo_wr; intermediate values never visible on hi/lo.
REQ-028 start accepted on the edge directly after done (E34 of previous op) is legal; back-to-back ops lose no cycle.

Reset
REQ-029 rst_n=0 forces immediately, regardless of clk: state=IDLE, counter=0, busy=0, done=0, div_zero=0, hi=0, lo=0.
REQ-030 Reset mid-operation aborts it; no done pulse; HI/LO read 0; first start after rst_n rises is accepted normally.

Verification
REQ-031 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done after E33, HI=0xFFFFFFFE, LO=0x00000001, busy 1 for E0..E33.
REQ-032 MULT -3 x 7 (0xFFFFFFFD, 0x00000007) -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-033 DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; then DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-034 DIVU 100 / 0 -> div_zero=1, LO=0xFFFFFFFF, HI=0x00000064; next DIVU 100/7 -> div_zero=0, LO=14, HI=2.
REQ-035 start (DIVU 9/2) and lo_wr asserted at E5 of a running MULTU -> both ignored; MULTU result unchanged.
REQ-036 rst_n low at E10 of DIV, released two cycles later -> all outputs 0, no done; new MULTU 6x7 -> LO=42, HI=0, 34 edges.
